neuron_seq_ctrl: RTL and testbench

NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

---
 rtl/neuron_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_neuron_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: sequencer for one integrate-and-fire neuron evaluation.
//
// One evaluation runs IDLE -> CLEAR -> SCAN (N_INPUTS cycles) -> DRAIN -> CMP -> DONE.
// Inputs whose captured spike bit is set are read from synapse memory and accumulated by an
// external MAC unit. The accumulated sum is then compared against the threshold. Latency is
// fixed at N_INPUTS+4 cycles from the accepting edge, whatever the spike count.
//
// Optional feature: define NSC_REFRACTORY_EN to suppress firing for REFRAC_COUNT evaluations
// after each spike.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   i_start           evaluation request, sampled only in IDLE
//   i_spike_vec       presynaptic spike bitmap, captured when i_start is accepted
//   i_threshold       unsigned firing threshold, sampled in CMP
//   o_mem_addr        synapse weight address (0 outside SCAN)
//   o_mem_rd_en       weight read strobe; data returns one cycle later
//   o_mac_clear       accumulator clear (CLEAR state)
//   o_mac_accumulate  accumulate strobe, o_mem_rd_en delayed one cycle
//   i_mac_sum         accumulator value from the MAC unit
//   o_busy            high in every state except IDLE
//   o_done            one-cycle completion pulse
//   o_spike           firing result of the last completed evaluation
module neuron_seq_ctrl #(
  parameter int unsigned N_INPUTS     = 16,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned SUM_WIDTH    = 16,
  parameter int unsigned REFRAC_COUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [N_INPUTS-1:0]   i_spike_vec,
  input  logic [SUM_WIDTH-1:0]  i_threshold,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd_en,
  output logic                  o_mac_clear,
  output logic                  o_mac_accumulate,
  input  logic [SUM_WIDTH-1:0]  i_mac_sum,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spike
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScan,
    StDrain,
    StCmp,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [N_INPUTS-1:0]   spike_vec_q, spike_vec_d;
  logic                  spike_q, spike_d;
  logic                  acc_q;
  logic                  above_thr;

`ifdef NSC_REFRACTORY_EN
  localparam int unsigned RefracW = (REFRAC_COUNT > 0) ? $clog2(REFRAC_COUNT + 1) : 1;
  logic [RefracW-1:0] refrac_q, refrac_d;
`endif

  assign above_thr = (i_mac_sum >= i_threshold);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StClear;
      StClear: state_d = StScan;
      StScan:  if (idx_q == LastIdx) state_d = StDrain;
      StDrain: state_d = StCmp;
      StCmp:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy      = (state_q != StIdle);
    o_done      = (state_q == StDone);
    o_mac_clear = (state_q == StClear);
    o_mem_addr  = '0;
    o_mem_rd_en = 1'b0;
    if (state_q == StScan) begin
      o_mem_addr  = idx_q;
      o_mem_rd_en = spike_vec_q[idx_q];
    end
  end

  assign o_mac_accumulate = acc_q;
  assign o_spike          = spike_q;

  // Datapath next-state
  always_comb begin
    idx_d       = idx_q;
    spike_vec_d = spike_vec_q;
    spike_d     = spike_q;
`ifdef NSC_REFRACTORY_EN
    refrac_d    = refrac_q;
`endif
    unique case (state_q)
      StIdle:  if (i_start) spike_vec_d = i_spike_vec;
      StClear: idx_d = '0;
      // Hold on the last index so the scan never wraps into a second pass.
      StScan:  if (idx_q != LastIdx) idx_d = idx_q + ADDR_WIDTH'(1);
      StCmp: begin
`ifdef NSC_REFRACTORY_EN
        if (refrac_q != '0) begin
          spike_d  = 1'b0;
          refrac_d = refrac_q - RefracW'(1);
        end else begin
          spike_d = above_thr;
          if (above_thr) refrac_d = RefracW'(REFRAC_COUNT);
        end
`else
        spike_d = above_thr;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      spike_vec_q <= '0;
      spike_q     <= 1'b0;
      acc_q       <= 1'b0;
`ifdef NSC_REFRACTORY_EN
      refrac_q    <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      spike_vec_q <= spike_vec_d;
      spike_q     <= spike_d;
      // Memory data lands one cycle after the read, so accumulate trails rd_en by one.
      acc_q       <= o_mem_rd_en;
`ifdef NSC_REFRACTORY_EN
      refrac_q    <= refrac_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Testbench for neuron_seq_ctrl with a behavioural synapse memory and MAC unit.
module tb_neuron_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_spike_vec;
  logic [15:0] i_threshold;
  logic [3:0]  o_mem_addr;
  logic        o_mem_rd_en;
  logic        o_mac_clear;
  logic        o_mac_accumulate;
  logic [15:0] i_mac_sum;
  logic        o_busy;
  logic        o_done;
  logic        o_spike;

  int n_checks = 0;
  int n_errors = 0;

  // Free-running event counters from the monitor
  int rd_cnt = 0, acc_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int overlap_cnt = 0, addr_bad_cnt = 0, rd_addr_sum = 0;

  // Per-evaluation deltas filled in by run_eval
  int lat, d_rd, d_acc, d_clr, d_dn, d_addr;

  logic [15:0] weights [16];
  logic [15:0] rd_data = '0;
  logic [15:0] mac_sum = '0;

  always #5 clk = ~clk;

  neuron_seq_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_spike_vec      (i_spike_vec),
    .i_threshold      (i_threshold),
    .o_mem_addr       (o_mem_addr),
    .o_mem_rd_en      (o_mem_rd_en),
    .o_mac_clear      (o_mac_clear),
    .o_mac_accumulate (o_mac_accumulate),
    .i_mac_sum        (i_mac_sum),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_spike          (o_spike)
  );

  assign i_mac_sum = mac_sum;

  // Synapse memory: one-cycle read latency
  always @(posedge clk) begin
    if (o_mem_rd_en) rd_data <= weights[o_mem_addr];
  end

  // MAC unit
  always @(posedge clk) begin
    if (o_mac_clear)           mac_sum <= '0;
    else if (o_mac_accumulate) mac_sum <= mac_sum + rd_data;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      rd_cnt       += int'(o_mem_rd_en);
      acc_cnt      += int'(o_mac_accumulate);
      clr_cnt      += int'(o_mac_clear);
      done_cnt     += int'(o_done);
      overlap_cnt  += int'(o_mac_clear && o_mac_accumulate);
      addr_bad_cnt += int'(!o_busy && (o_mem_addr != 4'd0));
      if (o_mem_rd_en) rd_addr_sum += (32'd1 << o_mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_spike"}, 32'(o_spike), 0);
    check({tag, "_clr"},   32'(o_mac_clear), 0);
    check({tag, "_acc"},   32'(o_mac_accumulate), 0);
    check({tag, "_rd"},    32'(o_mem_rd_en), 0);
    check({tag, "_addr"},  32'(o_mem_addr), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts one evaluation and returns #1 after the negedge of the DONE cycle (or on timeout).
  task automatic run_eval(input logic [15:0] vec, input logic [15:0] thr);
    int rd0, acc0, clr0, dn0, addr0;
    rd0 = rd_cnt; acc0 = acc_cnt; clr0 = clr_cnt; dn0 = done_cnt; addr0 = rd_addr_sum;
    @(negedge clk);
    i_start     = 1'b1;
    i_spike_vec = vec;
    i_threshold = thr;
    @(negedge clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    #1;
    d_rd   = rd_cnt - rd0;
    d_acc  = acc_cnt - acc0;
    d_clr  = clr_cnt - clr0;
    d_dn   = done_cnt - dn0;
    d_addr = rd_addr_sum - addr0;
  endtask

  initial begin
    logic [3:0] refrac_exp;
    int dn0;

    for (int i = 0; i < 16; i++) weights[i] = 16'(100 + i);
    weights[0] = 16'd10;
    weights[2] = 16'd7;

    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_spike_vec = '0;
    i_threshold = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Two active inputs, sum exactly at threshold
    run_eval(16'h0005, 16'd17);
    check("t1_latency", lat, 20);
    check("t1_rd_cnt", d_rd, 2);
    check("t1_rd_addrs", d_addr, 32'h5);
    check("t1_acc_cnt", d_acc, 2);
    check("t1_clr_cnt", d_clr, 1);
    check("t1_done_cnt", d_dn, 1);
    check("t1_sum", 32'(mac_sum), 17);
    check("t1_spike", 32'(o_spike), 1);

    // One above the sum: no spike, held through idle
    do_reset();
    run_eval(16'h0005, 16'd18);
    check("t2_latency", lat, 20);
    check("t2_spike", 32'(o_spike), 0);
    repeat (5) @(negedge clk);
    check("t2_spike_held", 32'(o_spike), 0);
    check("t2_idle_busy", 32'(o_busy), 0);

    // Empty spike vector
    do_reset();
    run_eval(16'h0000, 16'd0);
    check("t3_latency", lat, 20);
    check("t3_rd_cnt", d_rd, 0);
    check("t3_acc_cnt", d_acc, 0);
    check("t3_spike_thr0", 32'(o_spike), 1);
    run_eval(16'h0000, 16'd1);
    check("t3_spike_thr1", 32'(o_spike), 0);

    // Start pulses in SCAN, CMP and DONE are ignored
    dn0 = done_cnt;
    @(negedge clk);
    i_start     = 1'b1;
    i_spike_vec = 16'h0005;
    i_threshold = 16'd17;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      i_start = (c == 5 || c == 19 || c == 20);
      if (c == 20) check("t4_done_at_20", 32'(o_done), 1);
    end
    i_start = 1'b0;
    #1;
    check("t4_done_cnt", done_cnt - dn0, 1);
    check("t4_busy_end", 32'(o_busy), 0);

    // Reset in SCAN cycle 8 aborts immediately
    @(negedge clk);
    i_start     = 1'b1;
    i_spike_vec = 16'hFFFF;
    i_threshold = 16'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    check("t5_busy_pre", 32'(o_busy), 1);
    dn0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_quiet("t5_abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    check("t5_no_done", done_cnt - dn0, 0);
    run_eval(16'h0005, 16'd17);
    check("t5_latency", lat, 20);
    check("t5_sum", 32'(mac_sum), 17);
    check("t5_spike", 32'(o_spike), 1);

    // Four back-to-back above-threshold evaluations
`ifdef NSC_REFRACTORY_EN
    refrac_exp = 4'b1001;
`else
    refrac_exp = 4'b1111;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_eval(16'h0005, 16'd17);
      check($sformatf("t6_spike_%0d", k), 32'(o_spike), 32'(refrac_exp[3-k]));
      check($sformatf("t6_latency_%0d", k), lat, 20);
    end

    check("overlap_clr_acc", overlap_cnt, 0);
    check("addr_outside_scan", addr_bad_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
